// File: rtl/hdmi_audio_pkg.sv
// Shared types and field positions for the HDMI audio sample packet decoder.
package hdmi_audio_pkg;

  localparam logic [7:0]  HDR_TYPE_AUDIO_SAMPLE = 8'd2;
  localparam int unsigned CS_LENGTH_DEFAULT     = 192;

  localparam int unsigned HDR_PRESENT_LSB = 8;
  localparam int unsigned HDR_LAYOUT_BIT  = 12;
  localparam int unsigned HDR_B_LSB       = 20;

  localparam int unsigned SAMPLE_W      = 24;
  localparam int unsigned SUB_LEFT_LSB  = 0;
  localparam int unsigned SUB_RIGHT_LSB = 24;
  localparam int unsigned SUB_VL        = 48;
  localparam int unsigned SUB_UL        = 49;
  localparam int unsigned SUB_CL        = 50;
  localparam int unsigned SUB_PL        = 51;
  localparam int unsigned SUB_VR        = 52;
  localparam int unsigned SUB_UR        = 53;
  localparam int unsigned SUB_CR        = 54;
  localparam int unsigned SUB_PR        = 55;

  typedef struct packed {
    logic [23:0] left;
    logic [23:0] right;
    logic [1:0]  valid_bits;
  } audio_sample_t;

  typedef enum logic {
    IDLE,
    UNPACK
  } asp_state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/audio_sample_packet_decoder_if.sv
// Packet-in and sample-out handshake bundle of the audio sample packet decoder.
interface audio_sample_packet_decoder_if;
  logic             pkt_valid;
  logic             pkt_ready;
  logic [23:0]      header;
  logic [3:0][55:0] sub;
  logic             smp_valid;
  logic             smp_ready;
  logic [23:0]      smp_left;
  logic [23:0]      smp_right;
  logic [1:0]       smp_valid_bits;

  modport master (
    output pkt_valid, header, sub, smp_ready,
    input  pkt_ready, smp_valid, smp_left, smp_right, smp_valid_bits
  );

  modport slave (
    input  pkt_valid, header, sub, smp_ready,
    output pkt_ready, smp_valid, smp_left, smp_right, smp_valid_bits
  );
endinterface

// File: rtl/audio_sample_fifo.sv
// First-word-fall-through sample FIFO; a push into a full FIFO succeeds when a pop happens on the same edge.
module audio_sample_fifo
  import hdmi_audio_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic          clk_pixel,
  input  logic          reset_n,
  input  logic          push,
  input  audio_sample_t wr_data,
  input  logic          pop,
  output audio_sample_t rd_data,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  audio_sample_t   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/audio_sample_packet_decoder.sv
// HDMI 2-channel L-PCM audio sample packet decoder: unpacks samples into a FIFO and rebuilds channel-status blocks.
// Define ASP_PARITY_CHECK_EN to drop slots with bad per-channel parity and count them in err_parity.
module audio_sample_packet_decoder
  import hdmi_audio_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CS_LENGTH  = CS_LENGTH_DEFAULT
) (
  input  logic                     clk_pixel,
  input  logic                     reset_n,
  audio_sample_packet_decoder_if.slave bus,
  output logic [CS_LENGTH-1:0]     cs_left,
  output logic [CS_LENGTH-1:0]     cs_right,
  output logic                     cs_strobe,
  output logic                     cs_locked,
  output logic [15:0]              err_parity,
  output logic [15:0]              err_overflow,
  output logic [15:0]              err_sync
);

  localparam int unsigned           IDX_W    = $clog2(CS_LENGTH);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(CS_LENGTH - 1);

  asp_state_t           state;
  asp_state_t           state_nxt;
  logic [1:0]           slot;
  logic [3:0]           present_q;
  logic [3:0]           b_q;
  logic [3:0][55:0]     sub_q;
  logic [55:0]          cur;
  logic [IDX_W-1:0]     frame_idx;
  logic [IDX_W-1:0]     idx_nxt;
  logic [CS_LENGTH-1:0] work_l;
  logic [CS_LENGTH-1:0] work_r;
  logic [CS_LENGTH-1:0] work_l_nxt;
  logic [CS_LENGTH-1:0] work_r_nxt;
  logic                 accept_ok;
  logic                 present;
  logic                 b_flag;
  logic                 par_l;
  logic                 par_r;
  logic                 par_ok;
  logic                 push_req;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 overflow;
  logic                 sync_err;
  logic                 commit;
  logic                 unused_hdr;
  audio_sample_t        wr_data;
  audio_sample_t        head;

  assign accept_ok  = (bus.header[7:0] == HDR_TYPE_AUDIO_SAMPLE) && !bus.header[HDR_LAYOUT_BIT];
  assign unused_hdr = ^{bus.header[19:16], bus.header[15:13]};
  assign bus.pkt_ready = (state == IDLE);
  assign cur = sub_q[slot];

  assign par_l = ^{cur[SUB_PL], cur[SUB_CL], cur[SUB_UL], cur[SUB_VL], cur[SUB_LEFT_LSB +: SAMPLE_W]};
  assign par_r = ^{cur[SUB_PR], cur[SUB_CR], cur[SUB_UR], cur[SUB_VR], cur[SUB_RIGHT_LSB +: SAMPLE_W]};
`ifdef ASP_PARITY_CHECK_EN
  assign par_ok = !par_l && !par_r;
`else
  logic unused_parity;
  assign unused_parity = par_l ^ par_r;
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    present    = 1'b0;
    b_flag     = 1'b0;
    idx_nxt    = frame_idx;
    work_l_nxt = work_l;
    work_r_nxt = work_r;
    case (state)
      IDLE: begin
        if (bus.pkt_valid && accept_ok) state_nxt = UNPACK;
      end
      UNPACK: begin
        present = present_q[slot];
        b_flag  = b_q[slot];
        if (slot == 2'd3) state_nxt = IDLE;
      end
    endcase
    // The index advances for every present slot, whether or not its sample reaches the FIFO.
    if (present) begin
      if (b_flag || frame_idx == LAST_IDX) idx_nxt = '0;
      else                                 idx_nxt = frame_idx + IDX_W'(1);
      work_l_nxt[idx_nxt] = cur[SUB_CL];
      work_r_nxt[idx_nxt] = cur[SUB_CR];
    end
  end

  assign pop      = bus.smp_valid && bus.smp_ready;
  assign push_req = present && par_ok;
  assign overflow = push_req && fifo_full && !pop;
  assign sync_err = present && b_flag && cs_locked && (frame_idx != LAST_IDX);
  assign commit   = present && cs_locked && (idx_nxt == LAST_IDX);

  assign wr_data = '{left:       cur[SUB_LEFT_LSB +: SAMPLE_W],
                     right:      cur[SUB_RIGHT_LSB +: SAMPLE_W],
                     valid_bits: {cur[SUB_VR], cur[SUB_VL]}};

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      slot         <= '0;
      present_q    <= '0;
      b_q          <= '0;
      sub_q        <= '0;
      frame_idx    <= '0;
      work_l       <= '0;
      work_r       <= '0;
      cs_left      <= '0;
      cs_right     <= '0;
      cs_strobe    <= 1'b0;
      cs_locked    <= 1'b0;
      err_overflow <= '0;
      err_sync     <= '0;
    end else begin
      cs_strobe <= commit;
      if (state == IDLE) begin
        slot <= '0;
        if (bus.pkt_valid) begin
          present_q <= bus.header[HDR_PRESENT_LSB +: 4];
          b_q       <= bus.header[HDR_B_LSB +: 4];
          sub_q     <= bus.sub;
        end
      end else begin
        slot <= slot + 2'd1;
      end
      if (present) begin
        frame_idx <= idx_nxt;
        work_l    <= work_l_nxt;
        work_r    <= work_r_nxt;
        if (b_flag) cs_locked <= 1'b1;
      end
      // Copy includes the bit captured on this same edge.
      if (commit) begin
        cs_left  <= work_l_nxt;
        cs_right <= work_r_nxt;
      end
      if (sync_err) err_sync     <= sat_inc(err_sync);
      if (overflow) err_overflow <= sat_inc(err_overflow);
    end
  end

`ifdef ASP_PARITY_CHECK_EN
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n)                err_parity <= '0;
    else if (present && !par_ok) err_parity <= sat_inc(err_parity);
  end
`else
  assign err_parity = '0;
`endif

  audio_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .push      (push_req),
    .wr_data   (wr_data),
    .pop       (pop),
    .rd_data   (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.smp_valid      = !fifo_empty;
  assign bus.smp_left       = head.left;
  assign bus.smp_right      = head.right;
  assign bus.smp_valid_bits = head.valid_bits;

endmodule

// File: tb/tb_audio_sample_packet_decoder.sv
// Testbench for audio_sample_packet_decoder: table-driven packets plus hand-written channel-status, sync, overflow and reset sequences.
module tb_audio_sample_packet_decoder;
  import hdmi_audio_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CSL   = 192;
`ifdef ASP_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [23:0] hdr;
    logic [3:0]  badp;
    logic [7:0]  exp_idx;
    logic [15:0] exp_par;
    logic        exp_locked;
  } vec_t;

  logic             clk_pixel = 1'b0;
  logic             reset_n   = 1'b1;
  logic [CSL-1:0]   cs_left;
  logic [CSL-1:0]   cs_right;
  logic             cs_strobe;
  logic             cs_locked;
  logic [15:0]      err_parity;
  logic [15:0]      err_overflow;
  logic [15:0]      err_sync;

  audio_sample_packet_decoder_if bus();

  audio_sample_packet_decoder #(.FIFO_DEPTH(DEPTH), .CS_LENGTH(CSL)) dut (
    .clk_pixel    (clk_pixel),
    .reset_n      (reset_n),
    .bus          (bus.slave),
    .cs_left      (cs_left),
    .cs_right     (cs_right),
    .cs_strobe    (cs_strobe),
    .cs_locked    (cs_locked),
    .err_parity   (err_parity),
    .err_overflow (err_overflow),
    .err_sync     (err_sync)
  );

  always #5 clk_pixel = ~clk_pixel;

  int total   = 0;
  int bad     = 0;
  int strobes = 0;
  int exp_ovf = 0;
  audio_sample_t exp_q[$];

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk_pixel) begin
    audio_sample_t e;
    if (cs_strobe) strobes++;
    if (reset_n && bus.smp_valid && bus.smp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sample_unexpected got=%0h expected=none",
                 {bus.smp_left, bus.smp_right, bus.smp_valid_bits});
      end else begin
        e = exp_q.pop_front();
        check("sample", {bus.smp_left, bus.smp_right, bus.smp_valid_bits}, e);
      end
    end
  end

  function automatic logic [23:0] mk_hdr(input logic [7:0] hb0, input logic layout,
                                         input logic [3:0] present, input logic [3:0] b);
    return {b, 4'h0, 3'b000, layout, present, hb0};
  endfunction

  function automatic logic [3:0][55:0] mk_pkt(input int base, input logic [3:0] cl,
                                               input logic [3:0] cr, input logic [3:0] badp);
    logic [3:0][55:0] r;
    logic [23:0] l;
    logic [23:0] rt;
    logic vl, vr, pl, pr;
    for (int k = 0; k < 4; k++) begin
      l  = 24'(base + k + 1);
      rt = 24'h100001 + 24'(base + k);
      vl = l[0];
      vr = rt[1];
      pl = (^{cl[k], 1'b0, vl, l}) ^ badp[k];
      pr = ^{cr[k], 1'b0, vr, rt};
      r[k] = {pr, cr[k], 1'b0, vr, pl, cl[k], 1'b0, vl, rt, l};
    end
    return r;
  endfunction

  // Predicts which samples reach the FIFO, then performs the handshake.
  task automatic send(input logic [23:0] hdr, input logic [3:0][55:0] s, input bit hold_full);
    int n;
    audio_sample_t smp;
    logic bad_par;
    if (hdr[7:0] == 8'd2 && !hdr[12]) begin
      for (int k = 0; k < 4; k++) begin
        if (hdr[8 + k]) begin
          bad_par = (^{s[k][51:48], s[k][23:0]}) | (^{s[k][55:52], s[k][47:24]});
          smp = '{left: s[k][23:0], right: s[k][47:24], valid_bits: {s[k][52], s[k][48]}};
          if (!(PAR_EN && bad_par)) begin
            if (hold_full || exp_q.size() < DEPTH) exp_q.push_back(smp);
            else                                   exp_ovf++;
          end
        end
      end
    end
    bus.header    = hdr;
    bus.sub       = s;
    bus.pkt_valid = 1'b1;
    n = 0;
    while (!bus.pkt_ready && n < 20) begin
      @(posedge clk_pixel); #1;
      n++;
    end
    if (n == 20) begin
      total++;
      bad++;
      $display("FAIL handshake_timeout got=pkt_ready_low expected=pkt_ready_high");
    end
    @(posedge clk_pixel); #1;
    bus.pkt_valid = 1'b0;
    if (hold_full) bus.smp_ready = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !bus.pkt_ready) && n < 400) begin
      @(posedge clk_pixel); #1;
      n++;
    end
    repeat (3) @(posedge clk_pixel);
    #1;
    check("drain_empty", 192'(exp_q.size()), 192'd0);
  endtask

  task automatic reset_dut();
    bus.pkt_valid = 1'b0;
    bus.smp_ready = 1'b1;
    @(posedge clk_pixel); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk_pixel);
    #1;
    exp_q.delete();
    exp_ovf = 0;
    strobes = 0;
    reset_n = 1'b1;
    @(posedge clk_pixel); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    bus.pkt_valid = 1'b0;
    bus.header    = '0;
    bus.sub       = '0;
    bus.smp_ready = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk_pixel);
    #1;
    check("rst_pkt_ready", 192'(bus.pkt_ready), 192'd1);
    check("rst_smp_valid", 192'(bus.smp_valid), 192'd0);
    check("rst_smp_data", 192'({bus.smp_left, bus.smp_right, bus.smp_valid_bits}), 192'd0);
    check("rst_cs_left", cs_left, 192'd0);
    check("rst_cs_right", cs_right, 192'd0);
    check("rst_cs_flags", 192'({cs_strobe, cs_locked}), 192'd0);
    check("rst_errs", 192'({err_parity, err_overflow, err_sync}), 192'd0);
    check("rst_frame_idx", 192'(dut.frame_idx), 192'd0);
    reset_n = 1'b1;
    @(posedge clk_pixel); #1;

    tbl[0] = '{mk_hdr(8'd2,  1'b0, 4'hF, 4'h1), 4'h0, 8'd3, 16'd0, 1'b1};
    tbl[1] = '{mk_hdr(8'h84, 1'b0, 4'hF, 4'h1), 4'h0, 8'd3, 16'd0, 1'b1};
    tbl[2] = '{mk_hdr(8'd2,  1'b1, 4'hF, 4'h1), 4'h0, 8'd3, 16'd0, 1'b1};
    tbl[3] = '{mk_hdr(8'd2,  1'b0, 4'h5, 4'h0), 4'h0, 8'd5, 16'd0, 1'b1};
    tbl[4] = '{mk_hdr(8'd2,  1'b0, 4'hF, 4'h0), 4'h2, 8'd9, PAR_EN ? 16'd1 : 16'd0, 1'b1};
    tbl[5] = '{mk_hdr(8'd2,  1'b0, 4'h0, 4'h0), 4'h0, 8'd9, PAR_EN ? 16'd1 : 16'd0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].hdr, mk_pkt(i * 16, 4'h0, 4'h0, tbl[i].badp), 1'b0);
      drain();
      check($sformatf("vec%0d_idx", i), 192'(dut.frame_idx), 192'(tbl[i].exp_idx));
      check($sformatf("vec%0d_locked", i), 192'(cs_locked), 192'(tbl[i].exp_locked));
      check($sformatf("vec%0d_err_parity", i), 192'(err_parity), 192'(tbl[i].exp_par));
      check($sformatf("vec%0d_pkt_ready", i), 192'(bus.pkt_ready), 192'd1);
      check($sformatf("vec%0d_smp_valid", i), 192'(bus.smp_valid), 192'd0);
    end

    // Full channel-status block: C_L only at frame 0, C_R only at frame 191.
    reset_dut();
    for (int p = 0; p < 47; p++)
      send(mk_hdr(8'd2, 1'b0, 4'hF, (p == 0) ? 4'h1 : 4'h0),
           mk_pkt(p * 4, (p == 0) ? 4'h1 : 4'h0, 4'h0, 4'h0), 1'b0);
    drain();
    check("cs_no_early_strobe", 192'(strobes), 192'd0);
    send(mk_hdr(8'd2, 1'b0, 4'hF, 4'h0), mk_pkt(188, 4'h0, 4'h8, 4'h0), 1'b0);
    drain();
    check("cs_strobe_count", 192'(strobes), 192'd1);
    check("cs_left_block", cs_left, 192'h1);
    check("cs_right_block", cs_right, 192'h1 << 191);
    check("cs_frame_idx", 192'(dut.frame_idx), 192'd191);
    check("cs_errs", 192'({err_parity, err_overflow, err_sync}), 192'd0);

    // Early B at slot 2 of the 10th packet.
    reset_dut();
    for (int p = 0; p < 10; p++)
      send(mk_hdr(8'd2, 1'b0, 4'hF, (p == 0) ? 4'h1 : ((p == 9) ? 4'h4 : 4'h0)),
           mk_pkt(p * 4, 4'h0, 4'h0, 4'h0), 1'b0);
    drain();
    check("sync_err_count", 192'(err_sync), 192'd1);
    check("sync_frame_idx", 192'(dut.frame_idx), 192'd1);
    check("sync_no_strobe", 192'(strobes), 192'd0);
    for (int p = 0; p < 48; p++)
      send(mk_hdr(8'd2, 1'b0, 4'hF, 4'h0), mk_pkt(p * 4, 4'h0, 4'h0, 4'h0), 1'b0);
    drain();
    check("sync_realigned_strobe", 192'(strobes), 192'd1);
    check("sync_err_stable", 192'(err_sync), 192'd1);

    // Overflow with the consumer stalled.
    reset_dut();
    bus.smp_ready = 1'b0;
    for (int p = 0; p < 5; p++)
      send(mk_hdr(8'd2, 1'b0, 4'hF, (p == 0) ? 4'h1 : 4'h0), mk_pkt(p * 4, 4'h0, 4'h0, 4'h0), 1'b0);
    repeat (6) @(posedge clk_pixel);
    #1;
    check("ovf_count", 192'(err_overflow), 192'd4);
    check("ovf_model", 192'(err_overflow), 192'(exp_ovf));
    check("ovf_smp_valid", 192'(bus.smp_valid), 192'd1);
    bus.smp_ready = 1'b1;
    drain();

    // Push into a full FIFO while the consumer pops on the same edge.
    reset_dut();
    bus.smp_ready = 1'b0;
    for (int p = 0; p < 4; p++)
      send(mk_hdr(8'd2, 1'b0, 4'hF, 4'h0), mk_pkt(p * 4, 4'h0, 4'h0, 4'h0), 1'b0);
    repeat (6) @(posedge clk_pixel);
    #1;
    check("full_no_ovf", 192'(err_overflow), 192'd0);
    send(mk_hdr(8'd2, 1'b0, 4'hF, 4'h0), mk_pkt(16, 4'h0, 4'h0, 4'h0), 1'b1);
    drain();
    check("pushpop_no_ovf", 192'(err_overflow), 192'd0);

    // Reset in the middle of UNPACK.
    reset_dut();
    bus.smp_ready = 1'b0;
    send(mk_hdr(8'd2, 1'b0, 4'hF, 4'h1), mk_pkt(0, 4'h0, 4'h0, 4'h0), 1'b0);
    @(posedge clk_pixel); #1;
    check("midrst_pre_valid", 192'(bus.smp_valid), 192'd1);
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_smp_valid", 192'(bus.smp_valid), 192'd0);
    check("midrst_pkt_ready", 192'(bus.pkt_ready), 192'd1);
    repeat (2) @(posedge clk_pixel);
    #1;
    reset_n = 1'b1;
    repeat (6) @(posedge clk_pixel);
    #1;
    check("midrst_fifo_empty", 192'(bus.smp_valid), 192'd0);
    check("midrst_frame_idx", 192'(dut.frame_idx), 192'd0);
    bus.smp_ready = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
